// File: rtl/ahb_master_p_if.sv
// Bundles the user request/response channel and the AHB-Lite bus of ahb_master_p.
// Signal names match the original port list so existing hookups keep working.
interface ahb_master_p_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    input  hrdata, hready, hresp,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    output haddr, htrans, hwrite, hsize, hwdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    output hrdata, hready, hresp,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    input  haddr, htrans, hwrite, hsize, hwdata
  );
endinterface

// File: rtl/ahb_master_p.sv
// Single-transfer AHB-Lite master: one user request becomes one NONSEQ transfer,
// with alignment checking, slave error handling and a wait-state timeout.
module ahb_master_p #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_master_p_if.master bus
);

  localparam int         LANES    = DATA_W / 8;
  localparam int         LANE_W   = $clog2(LANES);
  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              herr_q, herr_d;
  logic              req_bad;

  function automatic logic misaligned(input logic [2:0] sz, input logic [2:0] a);
    logic m;
    case (sz)
      3'd1:    m = a[0];
      3'd2:    m = |a[1:0];
      3'd3:    m = |a[2:0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [2:0] sz);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (sz)
        3'd0:    r[8*i +: 8] = d[7:0];
        3'd1:    r[8*i +: 8] = d[8*(i%2) +: 8];
        3'd2:    r[8*i +: 8] = d[8*(i%4) +: 8];
        default: r[8*i +: 8] = d[8*i +: 8];
      endcase
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                input logic [LANE_W-1:0] lane,
                                                input logic [2:0] sz);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    sh = d >> {lane, 3'b000};
    r  = '0;
    case (sz)
      3'd0:    r[7:0]  = sh[7:0];
      3'd1:    r[15:0] = sh[15:0];
      3'd2:    r[31:0] = sh[31:0];
      default: r       = sh;
    endcase
    return r;
  endfunction

  assign req_bad = (bus.req_size > MAX_SIZE) ||
                   misaligned(bus.req_size, bus.req_addr[2:0]);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      herr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      herr_q   <= herr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    herr_d   = herr_q;

    case (state_q)
      S_IDLE: begin
        wcnt_d = '0;
        herr_d = 1'b0;
        if (bus.req_valid) begin
          // Rejected requests skip the bus, so the address-phase registers keep their last values.
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            haddr_d  = bus.req_addr;
            hwrite_d = bus.req_write;
            hsize_d  = bus.req_size;
            wdata_d  = bus.req_wdata;
            err_d    = 1'b0;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.hready) begin
          wcnt_d  = '0;
          state_d = S_DATA;
          if (hwrite_q) hwdata_d = replicate(wdata_q, hsize_q);
        end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
          wcnt_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bus.hready) begin
          state_d = S_RESP;
          if (bus.hresp || herr_q) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (!hwrite_q) rdata_d = extract(bus.hrdata, haddr_q[LANE_W-1:0], hsize_q);
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (bus.hresp) herr_d = 1'b1;
          if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        herr_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.htrans    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_master_p.sv
// Randomised bench for ahb_master_p: a driver plays both user and AHB slave,
// queueing predicted responses that an independent monitor checks.
module tb_ahb_master_p;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_master_p_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_master_p #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  typedef struct {
    logic          write;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            aw;
    int            dw;
    bit            serr;
    logic [DW-1:0] rdata;
  } txn_t;

  typedef struct {
    bit            err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          expq[$];
  exp_t          mon_e;
  logic [DW-1:0] model_rdata;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [2:0] sz, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input int aw, input int dw,
                              input bit se, input logic [DW-1:0] rd);
    txn_t t;
    t.write = w; t.size = sz; t.addr = a; t.wdata = wd;
    t.aw = aw; t.dw = dw; t.serr = se; t.rdata = rd;
    return t;
  endfunction

  function automatic bit is_bad(input txn_t t);
    if (t.size > 3'($clog2(DW/8))) return 1'b1;
    return (t.addr & ((32'd1 << t.size) - 32'd1)) != 0;
  endfunction

  // Lane replication by repeated doubling of the masked item.
  function automatic logic [DW-1:0] rep(input logic [DW-1:0] d, input logic [2:0] sz);
    int            w;
    logic [DW-1:0] m;
    logic [DW-1:0] v;
    w = 8 << sz;
    m = '1;
    m = m >> (DW - w);
    v = d & m;
    while (w < DW) begin
      v = v | (v << w);
      w = w * 2;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] ext(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                        input logic [2:0] sz);
    logic [DW-1:0] r;
    int            lane;
    r    = '0;
    lane = int'(a % (DW/8));
    for (int b = 0; b < (1 << sz); b++) r[8*b +: 8] = d[8*(lane+b) +: 8];
    return r;
  endfunction

  task automatic cyc();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic junk();
    bus.req_valid = 1'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_size  = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic resp_check();
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    bus.req_valid = 1'b0;
    chk("resp_cycle", {bus.rsp_valid, bus.busy, bus.htrans}, {1'b1, 1'b1, 2'b00});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
  endtask

  task automatic run(input txn_t t);
    exp_t          e;
    logic [DW-1:0] hw;
    int            la;
    int            ld;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = t.write;
    bus.req_size  = t.size;
    bus.req_addr  = t.addr;
    bus.req_wdata = t.wdata;
    if (is_bad(t) || t.aw >= TO || t.dw >= TO || t.serr) begin
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      if (!t.write) model_rdata = ext(t.rdata, t.addr, t.size);
    end
    e.rdata = model_rdata;
    expq.push_back(e);
    cyc();
    junk();
    if (is_bad(t)) begin
      resp_check();
      return;
    end
    la = (t.aw < TO) ? t.aw : TO;
    for (int c = 0; c < la; c++) begin
      bus.hready = 1'b0;
      chk("addr_phase_wait", {bus.htrans, bus.haddr, bus.hwrite, bus.hsize},
          {2'b10, t.addr, t.write, t.size});
      cyc();
      junk();
    end
    if (t.aw >= TO) begin
      resp_check();
      return;
    end
    bus.hready = 1'b1;
    chk("addr_phase", {bus.htrans, bus.haddr, bus.hwrite, bus.hsize},
        {2'b10, t.addr, t.write, t.size});
    cyc();
    junk();
    hw = t.write ? rep(t.wdata, t.size) : '0;
    ld = (t.dw < TO) ? t.dw : TO;
    for (int c = 0; c < ld; c++) begin
      bus.hready = 1'b0;
      bus.hresp  = 1'b0;
      bus.hrdata = $urandom;
      chk("data_phase_wait", {bus.htrans, t.write ? bus.hwdata : '0}, {2'b00, hw});
      cyc();
      junk();
    end
    if (t.dw >= TO) begin
      resp_check();
      return;
    end
    if (t.serr) begin
      bus.hready = 1'b0;
      bus.hresp  = 1'b1;
      bus.hrdata = $urandom;
      chk("data_phase_err1", {bus.htrans, t.write ? bus.hwdata : '0}, {2'b00, hw});
      cyc();
      junk();
      bus.hready = 1'b1;
      bus.hresp  = 1'b1;
      cyc();
    end else begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = t.rdata;
      chk("data_phase", {bus.htrans, t.write ? bus.hwdata : '0}, {2'b00, hw});
      cyc();
    end
    resp_check();
  endtask

  always @(negedge HCLK) begin
    if (!HRESET && bus.rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp at %0t: got rsp_valid=1 expected no response", $time);
      end else begin
        mon_e = expq.pop_front();
        chk("rsp_err", bus.rsp_err, mon_e.err);
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int   awp[7];
    int   dwp[7];
    txn_t t;
    awp = '{0, 0, 0, 1, 2, 15, 16};
    dwp = '{0, 0, 1, 3, 15, 16, 2};
    model_rdata   = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;

    #12;
    chk("reset_ctrl", {bus.htrans, bus.hwrite, bus.hsize, bus.rsp_valid, bus.rsp_err,
                       bus.busy, bus.req_ready}, 10'b0000000001);
    chk("reset_haddr_hwdata", {bus.haddr, bus.hwdata}, 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    cyc();

    run(mk(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0));
    run(mk(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 1'b0, 32'hAB000000));
    run(mk(1'b1, 3'd1, 32'h101, 32'h1234, 0, 0, 1'b0, 32'h0));
    run(mk(1'b0, 3'd2, 32'h200, 32'h0, 0, 3, 1'b0, 32'h12345678));
    run(mk(1'b0, 3'd2, 32'h204, 32'h0, 0, 16, 1'b0, 32'h55));
    run(mk(1'b0, 3'd2, 32'h208, 32'h0, 0, 15, 1'b0, 32'hCAFEF00D));
    run(mk(1'b0, 3'd1, 32'h20A, 32'h0, 0, 0, 1'b1, 32'h99999999));
    run(mk(1'b0, 3'd3, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0));
    run(mk(1'b1, 3'd0, 32'h3, 32'h5A, 16, 0, 1'b0, 32'h0));
    run(mk(1'b1, 3'd1, 32'h2, 32'hBEEF, 15, 2, 1'b0, 32'h0));

    // Reset while the data phase is stalled: no response may appear.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 3'd2;
    bus.req_addr  = 32'h300;
    cyc();
    bus.req_valid = 1'b0;
    bus.hready    = 1'b1;
    cyc();
    bus.hready = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    chk("midreset_ctrl", {bus.htrans, bus.hwrite, bus.hsize, bus.rsp_valid, bus.rsp_err,
                          bus.busy}, 0);
    chk("midreset_haddr_hwdata", {bus.haddr, bus.hwdata}, 0);
    chk("midreset_rdata", bus.rsp_rdata, 0);
    model_rdata = '0;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET     = 1'b0;
    bus.hready = 1'b1;
    cyc();
    chk("post_reset_idle", {bus.busy, bus.rsp_valid, bus.req_ready}, 3'b001);
    run(mk(1'b0, 3'd1, 32'h302, 32'h0, 0, 0, 1'b0, 32'h77665544));

    for (int i = 0; i < 300; i++) begin
      t.write = 1'($urandom);
      t.size  = ($urandom % 10 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      t.addr  = $urandom;
      if ($urandom % 5 != 0 && t.size <= 3'd2) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
      t.wdata = $urandom;
      t.aw    = awp[$urandom % 7];
      t.dw    = dwp[$urandom % 7];
      t.serr  = ($urandom % 7 == 0);
      if (t.serr && t.dw > 3) t.dw = t.dw % 4;
      t.rdata = $urandom;
      run(t);
    end

    for (int n = 0; n < 20 && expq.size() != 0; n++) cyc();
    chk("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ahb_master_p.md
AHB_MASTER_P -- requirements
Module: ahb_master_p

Interface
REQ-001 Parameter: ADDR_W, 32, AHB address width.
REQ-002 Parameter: DATA_W, 32, AHB data width; SHALL be 32 or 64.
REQ-003 Parameter: TIMEOUT, 16, max consecutive hready-low cycles per transfer before abort; SHALL be >= 2.
REQ-004 Port: HCLK  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: HRESET  in  1  reset, asynchronous, active-high.
REQ-006 Port: req_valid  in  1  user request present.
REQ-007 Port: req_ready  out  1  block can accept request this cycle.
REQ-008 Port: req_write  in  1  1=write, 0=read.
REQ-009 Port: req_size  in  3  log2(bytes): 0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
REQ-010 Port: req_addr  in  ADDR_W  byte address.
REQ-011 Port: req_wdata  in  DATA_W  write data, right-justified.
REQ-012 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-013 Port: rsp_err  out  1  qualifies rsp_valid: 1=error/timeout/misaligned.
REQ-014 Port: rsp_rdata  out  DATA_W  read data, right-justified, zero-extended; held until next rsp_valid.
REQ-015 Port: busy  out  1  high whenever state != IDLE.
REQ-016 Ports: haddr out ADDR_W; htrans out 2; hwrite out 1; hsize out 3; hwdata out DATA_W -- AHB-Lite master outputs.
REQ-017 Ports: hrdata in DATA_W; hready in 1; hresp in 1 -- AHB-Lite slave responses.

Function
REQ-018 States SHALL be IDLE, ADDR, DATA, RESP; req_ready = (state==IDLE) and SHALL NOT depend combinationally on req_valid.
REQ-019 Acceptance: req_valid && req_ready at an edge registers write/size/addr/wdata and moves IDLE->ADDR.
REQ-020 Misaligned request (req_addr mod 2^req_size != 0) or illegal size (>log2(DATA_W/8)) SHALL go IDLE->RESP, htrans stays IDLE, no bus transfer.
REQ-021 In ADDR: htrans=2'b10 (NONSEQ), haddr/hwrite/hsize = registered request; edge with hready=1 -> DATA.
REQ-022 In DATA: htrans=2'b00; hwdata = request data replicated across all lanes of its size; hwdata SHALL be stable while hready=0.
REQ-023 DATA, hready=1, hresp=0 -> RESP with err=0; for reads, capture hrdata shifted right by 8*(addr mod DATA_W/8), masked to 8*2^size bits.
REQ-024 DATA, hresp=1 with hready=0 (first error cycle): remain in DATA, htrans=IDLE; following hready=1 edge -> RESP with err=1, rsp_rdata unchanged.
REQ-025 Wait counter: cleared on entry to ADDR and on leaving ADDR; increments each edge in ADDR/DATA with hready=0; reaching TIMEOUT -> RESP with err=1, htrans forced IDLE.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, rsp_err per cause; RESP->IDLE unconditionally; minimum request-to-response latency = 3 cycles after acceptance (ADDR, DATA, RESP).
REQ-027 Outside ADDR, htrans SHALL be 2'b00; haddr/hwrite/hsize hold last values.
REQ-028 Back-to-back: next request accepted in the IDLE cycle after RESP; no overlap of transfers.
REQ-029 req_valid/req fields are ignored while req_ready=0.

Reset
REQ-030 HRESET high SHALL asynchronously force state=IDLE, wait counter=0, haddr=0, htrans=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no rsp_valid; first request after deassertion behaves as from cold reset.

Verification
REQ-032 Write word 0xDEADBEEF @0x100, hready=1 -> htrans=10 one cycle, haddr=0x100, hsize=2, next cycle hwdata=0xDEADBEEF, rsp_valid err=0 3 cycles after accept.
REQ-033 Read byte @0x103, hrdata=0xAB000000 -> rsp_rdata=0x000000AB, err=0.
REQ-034 Write half @0x101 -> no htrans NONSEQ, rsp_valid with err=1 next cycle.
REQ-035 Read with hready low 3 cycles in DATA, TIMEOUT=16 -> rsp after waits, err=0; hready held low 16 cycles -> rsp_err=1, htrans=00.
REQ-036 Slave two-cycle error (hresp=1/hready=0 then hresp=1/hready=1) -> rsp_valid err=1, rsp_rdata unchanged.
REQ-037 HRESET asserted while in DATA -> all outputs zero immediately, no rsp_valid; new request after release completes normally.
